// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dct_pkg
//  Description : Shared constants and types for the 32-point forward DCT
//                datapath (input butterfly, shift_add32, even-part stages).
//  Revision    : 1.0  initial release
// ============================================================================
package dct_pkg;

   localparam int DCT_N          = 32;
   localparam int DEF_IN_WIDTH   = 16;
   localparam int DEF_WIDTH      = 20;

   // Residual sample entering the transform and wide intermediate value.
   typedef logic signed [DEF_IN_WIDTH-1:0] sample_t;
   typedef logic signed [DEF_WIDTH-1:0]    coef_t;

endpackage
`default_nettype wire

// File: rtl/butterfly32_in_if.sv
`default_nettype none
// ============================================================================
//  Module      : butterfly32_in_if
//  Description : Sample input stream and butterfly result bundle of
//                butterfly32_in. master = sample source / result consumer,
//                slave = the butterfly itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface butterfly32_in_if
   import dct_pkg::*;
#(
   parameter int IN_WIDTH = DEF_IN_WIDTH,
   parameter int WIDTH    = DEF_WIDTH
);

   logic                       in_valid;
   logic                       in_first;
   logic signed [IN_WIDTH-1:0] in_data;
   logic signed [WIDTH-1:0]    a [DCT_N/2];
   logic signed [WIDTH-1:0]    b [DCT_N/2];
   logic                       out_valid;
   logic                       busy;
   logic                       err_short;

   modport master (
      output in_valid, in_first, in_data,
      input  a, b, out_valid, busy, err_short
   );

   modport slave (
      input  in_valid, in_first, in_data,
      output a, b, out_valid, busy, err_short
   );

endinterface
`default_nettype wire

// File: rtl/bfly_pair.sv
`default_nettype none
// ============================================================================
//  Module      : bfly_pair
//  Description : Combinational butterfly pair: sign-extends both operands to
//                WIDTH and returns their exact sum and difference (x - y).
//  Revision    : 1.0  initial release
// ============================================================================
module bfly_pair
   import dct_pkg::*;
#(
   parameter int IN_WIDTH = DEF_IN_WIDTH,
   parameter int WIDTH    = DEF_WIDTH
) (
   input  wire logic signed [IN_WIDTH-1:0] i_x,
   input  wire logic signed [IN_WIDTH-1:0] i_y,
   output logic signed [WIDTH-1:0]         o_sum,
   output logic signed [WIDTH-1:0]         o_diff
);

   logic signed [WIDTH-1:0] w_x;
   logic signed [WIDTH-1:0] w_y;

   // Signed size casts replicate the sign bit; WIDTH >= IN_WIDTH+1 keeps
   // both results exact.
   assign w_x    = WIDTH'(i_x);
   assign w_y    = WIDTH'(i_y);
   assign o_sum  = w_x + w_y;
   assign o_diff = w_x - w_y;

endmodule
`default_nettype wire

// File: rtl/butterfly32_in.sv
`default_nettype none
// ============================================================================
//  Module      : butterfly32_in
//  Description : First stage of the 32-point forward DCT. Assembles a row of
//                32 samples and produces a_k = x_k + x_(31-k) and
//                b_k = x_k - x_(31-k), k = 0..15, as one coherent registered
//                vector per row.
//  Revision    : 1.0  initial release
// ============================================================================
module butterfly32_in
   import dct_pkg::*;
#(
   parameter int IN_WIDTH = DEF_IN_WIDTH,
   parameter int WIDTH    = DEF_WIDTH
) (
   input  wire logic clk,
   input  wire logic rst_b,
   butterfly32_in_if.slave bus
);

   localparam int HALF  = DCT_N / 2;
   localparam int IDX_W = $clog2(DCT_N);

   // Row position of the next accepted sample; 0 means "waiting for x0".
   logic [IDX_W-1:0]           r_idx;
   logic signed [IN_WIDTH-1:0] r_hold    [HALF];
   logic signed [WIDTH-1:0]    r_stage_a [1:HALF-1];
   logic signed [WIDTH-1:0]    r_stage_b [1:HALF-1];
   logic signed [WIDTH-1:0]    r_a       [HALF];
   logic signed [WIDTH-1:0]    r_b       [HALF];
   logic                       r_out_valid;
   logic                       r_err_short;

   logic [IDX_W-2:0]           w_k;
   logic [IDX_W-2:0]           w_hold_idx;
   logic                       w_hold_we;
   logic                       w_pair_we;
   logic                       w_done;
   logic                       w_err;
   logic signed [WIDTH-1:0]    w_sum;
   logic signed [WIDTH-1:0]    w_diff;

   // Second half of the row: k = 31 - idx, which for idx 16..31 is the
   // bitwise complement of the low index bits.
   assign w_k = ~r_idx[IDX_W-2:0];

   // Decode what the current cycle does with the incoming sample.
   always_comb begin
      w_hold_idx = r_idx[IDX_W-2:0];
      w_hold_we  = 1'b0;
      w_pair_we  = 1'b0;
      w_done     = 1'b0;
      w_err      = 1'b0;
      if (bus.in_valid) begin
         if (bus.in_first) begin
            w_hold_idx = '0;
            w_hold_we  = 1'b1;
            w_err      = (r_idx != '0);
         end else if (r_idx == '0) begin
            w_err      = 1'b1;
         end else if (!r_idx[IDX_W-1]) begin
            w_hold_we  = 1'b1;
         end else begin
            w_pair_we  = 1'b1;
            w_done     = (w_k == '0);
         end
      end
   end

   bfly_pair #(
      .IN_WIDTH (IN_WIDTH),
      .WIDTH    (WIDTH)
   ) u_pair (
      .i_x    (r_hold[w_k]),
      .i_y    (bus.in_data),
      .o_sum  (w_sum),
      .o_diff (w_diff)
   );

   // First-half sample bank; contents are only meaningful inside a row.
   always_ff @(posedge clk) begin
      if (w_hold_we) begin
         r_hold[w_hold_idx] <= bus.in_data;
      end
   end

   // Pair results for k = 15..1 wait here until the row completes so the
   // outputs all switch on one edge.
   always_ff @(posedge clk) begin
      if (w_pair_we && !w_done) begin
         r_stage_a[w_k] <= w_sum;
         r_stage_b[w_k] <= w_diff;
      end
   end

   // Row sequencing, status pulses and the coherent output vector.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_err_short <= 1'b0;
         for (int i = 0; i < HALF; i++) begin
            r_a[i] <= '0;
            r_b[i] <= '0;
         end
      end else begin
         r_out_valid <= w_done;
         r_err_short <= w_err;
         if (bus.in_valid) begin
            if (bus.in_first) begin
               r_idx <= IDX_W'(1);
            end else if (r_idx != '0) begin
               r_idx <= r_idx + IDX_W'(1);
            end
         end
         if (w_done) begin
            r_a[0] <= w_sum;
            r_b[0] <= w_diff;
            for (int i = 1; i < HALF; i++) begin
               r_a[i] <= r_stage_a[i];
               r_b[i] <= r_stage_b[i];
            end
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.err_short = r_err_short;
   assign bus.busy      = (r_idx != '0);

   generate
      for (genvar gi = 0; gi < HALF; gi++) begin : g_out
         assign bus.a[gi] = r_a[gi];
         assign bus.b[gi] = r_b[gi];
      end
   endgenerate

endmodule
`default_nettype wire
